// File: rtl/timestamp_unit.sv
// Free-running timestamp counter in units of UNIT_PS with drift-free fractional
// accumulation, wrap pulse, and per-channel rising-edge timestamp capture.
module timestamp_unit #(
    parameter int CLK_PERIOD_PS = 10000,
    parameter int UNIT_PS       = 1000,
    parameter int TS_W          = 32,
    parameter int NUM_CH        = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en_i,
    input  logic                     clr_i,
    input  logic [NUM_CH-1:0]        ev_i,
    input  logic [NUM_CH-1:0]        ack_i,
    output logic [TS_W-1:0]          time_o,
    output logic                     wrap_o,
    output logic [NUM_CH*TS_W-1:0]   ts_o,
    output logic [NUM_CH-1:0]        valid_o,
    output logic [NUM_CH-1:0]        overrun_o
);

    localparam int INC   = CLK_PERIOD_PS / UNIT_PS;
    localparam int FRAC  = CLK_PERIOD_PS % UNIT_PS;
    localparam int RES_W = $clog2(UNIT_PS) + 1;

    localparam logic [RES_W:0] FRAC_V = (RES_W+1)'(FRAC);
    localparam logic [RES_W:0] UNIT_V = (RES_W+1)'(UNIT_PS);
    localparam logic [TS_W:0]  INC_V  = (TS_W+1)'(INC);

    logic [RES_W-1:0]  res;
    logic [RES_W:0]    res_sum;
    logic [RES_W-1:0]  res_nxt;
    logic              carry;
    logic [TS_W:0]     time_sum;
    logic [NUM_CH-1:0] ev_q;
    logic [NUM_CH-1:0] rise;
    logic              armed;

    // The residue carries the sub-unit remainder so long runs never drift.
    always_comb begin
        res_sum  = {1'b0, res} + FRAC_V;
        carry    = (res_sum >= UNIT_V);
        res_nxt  = carry ? RES_W'(res_sum - UNIT_V) : RES_W'(res_sum);
        time_sum = {1'b0, time_o} + INC_V + {{TS_W{1'b0}}, carry};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            time_o <= '0;
            res    <= '0;
            wrap_o <= 1'b0;
        end else if (clr_i) begin
            time_o <= '0;
            res    <= '0;
            wrap_o <= 1'b0;
        end else if (en_i) begin
            time_o <= time_sum[TS_W-1:0];
            res    <= res_nxt;
            wrap_o <= time_sum[TS_W];
        end else begin
            wrap_o <= 1'b0;
        end
    end

    // armed stays low for the first cycle after reset so that a level already
    // high at release is loaded into ev_q instead of being seen as a rise.
    always_comb begin
        rise = armed ? (ev_i & ~ev_q) : '0;
    end

    // Handshake: valid_o[c] rises with a capture and stays high until the edge
    // that samples ack_i[c] high; a rise at that same edge re-captures and keeps
    // valid_o[c] set. A rise while valid and unacknowledged is lost (overrun).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_o      <= '0;
            valid_o   <= '0;
            overrun_o <= '0;
            ev_q      <= '0;
            armed     <= 1'b0;
        end else begin
            ev_q  <= ev_i;
            armed <= 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (rise[c]) begin
                    if (!valid_o[c] || ack_i[c]) begin
                        ts_o[c*TS_W +: TS_W] <= time_o;
                        valid_o[c]           <= 1'b1;
                    end else begin
                        overrun_o[c] <= 1'b1;
                    end
                end else if (ack_i[c]) begin
                    valid_o[c] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_timestamp_unit.sv
// Bench for timestamp_unit: four instances (integer, fractional, slow-unit, 8-bit
// wrap) driven by directed vectors; a queue-based monitor checks each cycle.
module tb_timestamp_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: default integer rate, 4 channels
    logic         en_a, clr_a;
    logic [3:0]   ev_a, ack_a;
    logic [31:0]  time_a;
    logic         wrap_a;
    logic [127:0] ts_a;
    logic [3:0]   valid_a, overrun_a;

    // Instances B (2500/1000), C (1000/4000), D (8-bit wrap, +10/cycle)
    logic         en_b, en_c, en_d, clr_d;
    logic [15:0]  time_b, time_c, ts_b, ts_c;
    logic [7:0]   time_d, ts_d;
    logic         wrap_b, wrap_c, wrap_d;
    logic         valid_b, valid_c, valid_d, ovr_b, ovr_c, ovr_d;

    timestamp_unit #(.CLK_PERIOD_PS(10000), .UNIT_PS(1000), .TS_W(32), .NUM_CH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .en_i(en_a), .clr_i(clr_a), .ev_i(ev_a), .ack_i(ack_a),
        .time_o(time_a), .wrap_o(wrap_a), .ts_o(ts_a), .valid_o(valid_a), .overrun_o(overrun_a));

    timestamp_unit #(.CLK_PERIOD_PS(2500), .UNIT_PS(1000), .TS_W(16), .NUM_CH(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en_i(en_b), .clr_i(1'b0), .ev_i(1'b0), .ack_i(1'b0),
        .time_o(time_b), .wrap_o(wrap_b), .ts_o(ts_b), .valid_o(valid_b), .overrun_o(ovr_b));

    timestamp_unit #(.CLK_PERIOD_PS(1000), .UNIT_PS(4000), .TS_W(16), .NUM_CH(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .en_i(en_c), .clr_i(1'b0), .ev_i(1'b0), .ack_i(1'b0),
        .time_o(time_c), .wrap_o(wrap_c), .ts_o(ts_c), .valid_o(valid_c), .overrun_o(ovr_c));

    timestamp_unit #(.CLK_PERIOD_PS(10000), .UNIT_PS(1000), .TS_W(8), .NUM_CH(1)) dut_d (
        .clk(clk), .rst_n(rst_n), .en_i(en_d), .clr_i(clr_d), .ev_i(1'b0), .ack_i(1'b0),
        .time_o(time_d), .wrap_o(wrap_d), .ts_o(ts_d), .valid_o(valid_d), .overrun_o(ovr_d));

    typedef struct packed {
        logic [15:0] cyc;
        logic [7:0]  kind;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kind_name(input int kind);
        case (kind)
            0: return "a_time";
            1: return "a_wrap";
            2: return "a_valid";
            3: return "a_overrun";
            4: return "a_ts0";
            5: return "a_ts1";
            6: return "a_ts2";
            7: return "a_ts3";
            8: return "b_time";
            9: return "c_time";
            10: return "d_time";
            11: return "d_wrap";
            default: return "unknown";
        endcase
    endfunction

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            0: return time_a;
            1: return {31'b0, wrap_a};
            2: return {28'b0, valid_a};
            3: return {28'b0, overrun_a};
            4, 5, 6, 7: return ts_a[(kind-4)*32 +: 32];
            8: return {16'b0, time_b};
            9: return {16'b0, time_c};
            10: return {24'b0, time_d};
            11: return {31'b0, wrap_d};
            default: return 32'hdead_beef;
        endcase
    endfunction

    // Monitor: pops every expectation due at this cycle and compares it.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && int'(exp_q[0].cyc) <= cyc) begin
            exp_t e;
            logic [31:0] act;
            e = exp_q.pop_front();
            act = actual(int'(e.kind));
            checks++;
            if (int'(e.cyc) != cyc || act !== e.val) begin
                errors++;
                $display("FAIL %s cycle %0d: got %0d expected %0d", kind_name(int'(e.kind)),
                         cyc, act, e.val);
            end
        end
    end

    // Expectation for the state right after the next rising edge.
    task automatic push_exp(input int kind, input logic [31:0] val);
        exp_t e;
        e.cyc  = 16'(cyc + 1);
        e.kind = 8'(kind);
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_a_zero();
        push_exp(0, 0); push_exp(1, 0); push_exp(2, 0); push_exp(3, 0);
        for (int c = 0; c < 4; c++) push_exp(4 + c, 0);
    endtask

    int b_tab[4] = '{2, 5, 7, 10};

    initial begin
        rst_n = 1'b0;
        en_a = 0; clr_a = 0; ev_a = '0; ack_a = '0;
        en_b = 0; en_c = 0; en_d = 0; clr_d = 0;

        for (int i = 0; i < 3; i++) begin
            exp_a_zero();
            push_exp(10, 0); push_exp(11, 0);
            tick();
        end

        rst_n = 1'b1;
        push_exp(0, 0);
        tick();

        // Integer, fractional and slow-unit rates side by side
        for (int i = 1; i <= 8; i++) begin
            en_a = (i <= 5);
            en_b = (i <= 4);
            en_c = 1'b1;
            push_exp(0, 10 * ((i <= 5) ? i : 5));
            push_exp(8, b_tab[(i <= 4) ? i - 1 : 3]);
            push_exp(9, i / 4);
            tick();
        end
        en_a = 0; en_b = 0; en_c = 0;

        // Clear wins over enable and does not pulse wrap
        clr_a = 1; en_a = 1;
        push_exp(0, 0); push_exp(1, 0);
        tick();
        clr_a = 0;

        for (int k = 1; k <= 48; k++) begin
            case (k)
                1:  begin en_a = 1; en_d = 1; end
                5:  ev_a = 4'b0011;
                7:  begin ev_a = 4'b0010; ack_a = 4'b0010; end
                8:  begin ev_a = 4'b0000; ack_a = 4'b0000; end
                9:  ev_a = 4'b0001;
                10: ev_a = 4'b0000;
                13: begin ev_a = 4'b0001; ack_a = 4'b0001; end
                14: begin ev_a = 4'b0000; ack_a = 4'b0100; end
                15: begin ev_a = 4'b1111; ack_a = 4'b0000; clr_a = 1; end
                16: begin ev_a = 4'b0000; ack_a = 4'b0100; clr_a = 0; end
                17: ack_a = 4'b0000;
                28: clr_d = 1;
                29: begin clr_d = 0; en_d = 0; end
                46: begin rst_n = 0; ev_a = 4'b1111; end
                47: rst_n = 1;
                default: ;
            endcase

            if (k < 15)       push_exp(0, 10 * k);
            else if (k == 15) push_exp(0, 0);
            else if (k <= 45) push_exp(0, 10 * (k - 15));
            else if (k == 47) push_exp(0, 10);
            else if (k == 48) push_exp(0, 20);

            case (k)
                5:  begin push_exp(2, 4'b0011); push_exp(4, 40); push_exp(5, 40); push_exp(3, 0); end
                6:  begin push_exp(2, 4'b0011); push_exp(5, 40); end
                7:  push_exp(2, 4'b0001);
                9:  begin push_exp(2, 4'b0001); push_exp(4, 40); push_exp(3, 4'b0001); end
                13: begin push_exp(2, 4'b0001); push_exp(4, 120); push_exp(3, 4'b0001); end
                14: begin push_exp(2, 4'b0001); push_exp(3, 4'b0001); end
                15: begin
                    push_exp(2, 4'b1111); push_exp(3, 4'b0001); push_exp(1, 0);
                    push_exp(4, 120); push_exp(5, 140); push_exp(6, 140); push_exp(7, 140);
                end
                16: push_exp(2, 4'b1011);
                24: begin push_exp(10, 240); push_exp(11, 0); end
                25: begin push_exp(10, 250); push_exp(11, 0); end
                26: begin push_exp(10, 4);   push_exp(11, 1); end
                27: begin push_exp(10, 14);  push_exp(11, 0); end
                28: begin push_exp(10, 0);   push_exp(11, 0); end
                45: begin
                    push_exp(2, 4'b1011); push_exp(3, 4'b0001);
                    push_exp(4, 120); push_exp(5, 140); push_exp(7, 140);
                end
                46: exp_a_zero();
                47: begin push_exp(2, 0); push_exp(3, 0); end
                48: begin
                    push_exp(2, 0); push_exp(3, 0);
                    for (int c = 0; c < 4; c++) push_exp(4 + c, 0);
                end
                default: ;
            endcase
            tick();
        end

        en_a = 0; ev_a = '0;
        tick();
        tick();
        if (exp_q.size() != 0) begin
            errors += exp_q.size();
            $display("FAIL leftover_expectations: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
